// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single memory bus port between the IF stage (instruction fetch)
// and the MEM stage (load/store). MEM has priority. Each access gets a
// bounded wait: if bus_ready does not arrive within TIMEOUT_CYC cycles, the
// access is aborted and acknowledged with err=1.
//
// Parameters
//   TIMEOUT_CYC  maximum wait cycles in a busy state (1..255, default 255)
//
// Optional feature
//   MEMARB_ALIGN_CHECK_EN  when defined, misaligned requests are rejected
//                          without touching the bus (ack with err=1).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request and byte address
//   if_inst/if_ack           fetched word and one-cycle completion pulse
//   mem_req/mem_we/mem_sel   data request, write flag, byte enables
//   mem_addr/mem_wdata       data byte address, store data
//   mem_rdata/mem_ack        load data and one-cycle completion pulse
//   err                      accompanies an ack: timeout or misalignment
//   stall_req                pipeline stall while any requester is unserved
//   bus_ce/bus_we/bus_sel    registered memory controls
//   bus_addr/bus_wdata       registered memory address / write data
//   bus_rdata/bus_ready      memory read data and completion strobe
//------------------------------------------------------------------------------
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        err,
    output logic        stall_req,
    output logic        bus_ce,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic        err_q, err_d;
    logic        bus_ce_q, bus_ce_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        if_new_s;
    logic        mem_new_s;
    logic        if_mis_s;
    logic        mem_mis_s;

`ifdef MEMARB_ALIGN_CHECK_EN
    // Word accesses need addr[1:0]==0, halfword lanes need addr[0]==0.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [3:0] sel);
        logic bad;
        bad = 1'b0;
        if (sel == 4'b1111) begin
            bad = (addr_lo != 2'b00);
        end else if ((sel == 4'b0011) || (sel == 4'b1100)) begin
            bad = addr_lo[0];
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    assign if_mis_s  = is_misaligned(if_addr[1:0], 4'b1111);
    assign mem_mis_s = is_misaligned(mem_addr[1:0], mem_sel);
`else
    assign if_mis_s  = 1'b0;
    assign mem_mis_s = 1'b0;
`endif

    // The ack cycle doubles as the IDLE decision cycle; the request being
    // acknowledged right now is still high, so it must not be re-served.
    assign if_new_s  = if_req  & ~if_ack_q;
    assign mem_new_s = mem_req & ~mem_ack_q;

    assign stall_req = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign err       = err_q;
    assign bus_ce    = bus_ce_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            bus_ce_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            if_inst_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            err_q       <= err_d;
            bus_ce_q    <= bus_ce_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        err_d       = 1'b0;
        bus_ce_d    = bus_ce_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_new_s) begin
                    if (mem_mis_s) begin
                        // Rejected without a bus cycle.
                        mem_ack_d   = 1'b1;
                        err_d       = 1'b1;
                        mem_rdata_d = 32'd0;
                    end else begin
                        bus_ce_d    = 1'b1;
                        bus_we_d    = mem_we;
                        bus_sel_d   = mem_sel;
                        bus_addr_d  = mem_addr;
                        bus_wdata_d = mem_wdata;
                        cnt_d       = 8'd0;
                        state_d     = ST_MEM_BUSY;
                    end
                end else if (if_new_s) begin
                    if (if_mis_s) begin
                        if_ack_d  = 1'b1;
                        err_d     = 1'b1;
                        if_inst_d = 32'd0;
                    end else begin
                        bus_ce_d    = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_sel_d   = 4'b1111;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = 32'd0;
                        cnt_d       = 8'd0;
                        state_d     = ST_IF_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_IF_BUSY, ST_MEM_BUSY: begin
                if (bus_ready) begin
                    bus_ce_d = 1'b0;
                    state_d  = ST_IDLE;
                    if (state_q == ST_IF_BUSY) begin
                        if_ack_d  = 1'b1;
                        if_inst_d = bus_rdata;
                    end else begin
                        mem_ack_d   = 1'b1;
                        // Stores return zero data.
                        mem_rdata_d = bus_we_q ? 32'd0 : bus_rdata;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    // Abort: ack with err and zero data.
                    bus_ce_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                    if (state_q == ST_IF_BUSY) begin
                        if_ack_d  = 1'b1;
                        if_inst_d = 32'd0;
                    end else begin
                        mem_ack_d   = 1'b1;
                        mem_rdata_d = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                bus_ce_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

endmodule
